s3_run_ctrl: RTL and testbench

Run-control sequencer for the s3 micro-sequencer core. It sits between the host control bits and the s3 program counter / decode stage and decides every cycle whether the core advances one instruction. It handles start-at-entry, stop, single-step, PC breakpoint, HALT instructions and counted WAIT stalls. It also keeps a retired-instruction counter for debug.

---
 rtl/s3_pkg.sv | 29 ++
 rtl/s3_run_ctrl.sv | 163 ++++++++++++++++
 tb/tb_s3_run_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/s3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : s3_pkg
// Brief    : Shared types and constants for the s3 micro-sequencer core.
// Revision : 1.0
// ============================================================================
package s3_pkg;

    localparam int PC_W_DEF   = 8;
    localparam int WCNT_W_DEF = 8;
    localparam int RCNT_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_WAIT = 3'd3,
        ST_STEP = 3'd4,
        ST_HALT = 3'd5
    } run_state_e;

    // HC_INSN doubles as the "stopped after a single step" code.
    localparam logic [1:0] HC_NONE = 2'd0;
    localparam logic [1:0] HC_STOP = 2'd1;
    localparam logic [1:0] HC_BP   = 2'd2;
    localparam logic [1:0] HC_INSN = 2'd3;

endpackage
`default_nettype wire

// File: rtl/s3_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : s3_run_ctrl
// Brief    : Run-control sequencer deciding each cycle whether the s3 core
//            commits the instruction at pc; tracks retired instructions.
// Revision : 1.0
// ============================================================================
module s3_run_ctrl
    import s3_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int WCNT_W = WCNT_W_DEF,
    parameter int RCNT_W = RCNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctl_start,
    input  logic              ctl_stop,
    input  logic              ctl_cont,
    input  logic              ctl_step,
    input  logic [PC_W-1:0]   ctl_entry,
    input  logic              ctl_bp_en,
    input  logic [PC_W-1:0]   ctl_bp_addr,
    input  logic [PC_W-1:0]   pc,
    input  logic              op_halt,
    input  logic              op_wait,
    input  logic [WCNT_W-1:0] op_wait_cnt,
    output logic              core_ce,
    output logic              pc_load,
    output logic [PC_W-1:0]   pc_load_val,
    output logic              running,
    output logic              halted,
    output logic [1:0]        halt_cause,
    output logic [RCNT_W-1:0] retired
);

    run_state_e        r_state;
    logic [WCNT_W-1:0] r_wcnt;
    logic              r_resume;
    logic              r_pc_load;
    logic [PC_W-1:0]   r_pc_load_val;
    logic              r_running;
    logic              r_halted;
    logic [1:0]        r_halt_cause;
    logic [RCNT_W-1:0] r_retired;

    logic              w_bp_hit;
    logic              w_ce;

    // The resume flag lets a run leave the address it is parked on.
    assign w_bp_hit = ctl_bp_en && (pc == ctl_bp_addr) && !r_resume;

    always_comb begin
        w_ce = 1'b0;
        case (r_state)
            ST_RUN:  w_ce = !ctl_stop && !w_bp_hit && !op_halt;
            ST_STEP: w_ce = !ctl_stop && !op_halt;
            default: w_ce = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_wcnt        <= '0;
            r_resume      <= 1'b0;
            r_pc_load     <= 1'b0;
            r_pc_load_val <= '0;
            r_running     <= 1'b0;
            r_halted      <= 1'b0;
            r_halt_cause  <= HC_NONE;
            r_retired     <= '0;
        end else begin
            r_pc_load <= 1'b0;
            if (w_ce && (r_retired != {RCNT_W{1'b1}})) begin
                r_retired <= r_retired + 1'b1;
            end

            case (r_state)
                ST_IDLE, ST_HALT: begin
                    // A stop pulse in these states blocks every lower-priority pulse.
                    if (!ctl_stop) begin
                        if (ctl_start) begin
                            r_state       <= ST_LOAD;
                            r_pc_load     <= 1'b1;
                            r_pc_load_val <= ctl_entry;
                            r_retired     <= '0;
                            r_halt_cause  <= HC_NONE;
                            r_running     <= 1'b1;
                            r_halted      <= 1'b0;
                        end else if ((r_state == ST_HALT) && ctl_cont) begin
                            r_state   <= ST_RUN;
                            r_resume  <= 1'b1;
                            r_running <= 1'b1;
                            r_halted  <= 1'b0;
                        end else if ((r_state == ST_HALT) && ctl_step) begin
                            r_state   <= ST_STEP;
                            r_running <= 1'b1;
                            r_halted  <= 1'b0;
                        end
                    end
                end

                ST_LOAD: begin
                    r_state  <= ST_RUN;
                    r_resume <= 1'b1;
                end

                ST_RUN: begin
                    r_resume <= 1'b0;
                    if (ctl_stop || w_bp_hit || op_halt) begin
                        r_state      <= ST_HALT;
                        r_running    <= 1'b0;
                        r_halted     <= 1'b1;
                        r_halt_cause <= ctl_stop ? HC_STOP :
                                        w_bp_hit ? HC_BP   : HC_INSN;
                    end else if (op_wait && (op_wait_cnt != '0)) begin
                        r_state <= ST_WAIT;
                        r_wcnt  <= op_wait_cnt;
                    end
                end

                ST_WAIT: begin
                    if (ctl_stop) begin
                        r_state      <= ST_HALT;
                        r_wcnt       <= '0;
                        r_running    <= 1'b0;
                        r_halted     <= 1'b1;
                        r_halt_cause <= HC_STOP;
                    end else begin
                        r_wcnt <= r_wcnt - 1'b1;
                        if (r_wcnt == WCNT_W'(1)) begin
                            r_state <= ST_RUN;
                        end
                    end
                end

                ST_STEP: begin
                    r_state      <= ST_HALT;
                    r_running    <= 1'b0;
                    r_halted     <= 1'b1;
                    r_halt_cause <= ctl_stop ? HC_STOP : HC_INSN;
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                    r_halted  <= 1'b0;
                end
            endcase
        end
    end

    assign core_ce     = w_ce;
    assign pc_load     = r_pc_load;
    assign pc_load_val = r_pc_load_val;
    assign running     = r_running;
    assign halted      = r_halted;
    assign halt_cause  = r_halt_cause;
    assign retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_s3_run_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_s3_run_ctrl
// Brief    : Self-checking bench for s3_run_ctrl with a program-level model.
// Revision : 1.0
// ============================================================================
module tb_s3_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ctl_start = 1'b0, ctl_stop = 1'b0, ctl_cont = 1'b0, ctl_step = 1'b0;
    logic [7:0]  ctl_entry = '0;
    logic        ctl_bp_en = 1'b0;
    logic [7:0]  ctl_bp_addr = '0;
    logic [7:0]  pc = '0;
    logic        op_halt = 1'b0, op_wait = 1'b0;
    logic [7:0]  op_wait_cnt = '0;
    logic        core_ce, pc_load, running, halted;
    logic [7:0]  pc_load_val;
    logic [1:0]  halt_cause;
    logic [15:0] retired;

    always #5 clk = ~clk;

    s3_run_ctrl #(.PC_W(8), .WCNT_W(8), .RCNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ctl_start(ctl_start), .ctl_stop(ctl_stop), .ctl_cont(ctl_cont), .ctl_step(ctl_step),
        .ctl_entry(ctl_entry), .ctl_bp_en(ctl_bp_en), .ctl_bp_addr(ctl_bp_addr),
        .pc(pc), .op_halt(op_halt), .op_wait(op_wait), .op_wait_cnt(op_wait_cnt),
        .core_ce(core_ce), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .running(running), .halted(halted), .halt_cause(halt_cause), .retired(retired)
    );

    // Program image seen by the bench's own core model.
    bit         prog_halt [256];
    bit         prog_wait [256];
    logic [7:0] prog_cnt  [256];

    // Model: a mode, pending stall cycles, resume flag, cause, retired count, core PC.
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_STEP = 3, M_HALT = 4;
    int         m_mode, m_stall, m_cause, m_ret;
    bit         m_resume, exp_ce;
    logic [7:0] m_plv, m_pc;
    logic [29:0] exp_vec, act_vec;
    int         n_checks = 0, n_pass = 0;

    task automatic model_reset();
        m_mode = M_IDLE; m_stall = 0; m_cause = 0; m_ret = 0;
        m_resume = 0; m_plv = 8'h00; m_pc = 8'h00; exp_ce = 0;
    endtask

    function automatic bit bp_now();
        return ctl_bp_en && (pc == ctl_bp_addr) && !m_resume;
    endfunction

    // Apply one cycle of inputs at the falling edge and form expectations.
    task automatic drive(input bit st, input bit sp, input bit ct, input bit sq, input logic [7:0] entry);
        @(negedge clk);
        rst_n = 1'b1;
        ctl_start = st; ctl_stop = sp; ctl_cont = ct; ctl_step = sq; ctl_entry = entry;
        pc = m_pc;
        op_halt = prog_halt[m_pc]; op_wait = prog_wait[m_pc]; op_wait_cnt = prog_cnt[m_pc];
        #1;
        if (m_mode == M_RUN && m_stall == 0) exp_ce = !sp && !bp_now() && !op_halt;
        else if (m_mode == M_STEP)          exp_ce = !sp && !op_halt;
        else                                exp_ce = 1'b0;
        exp_vec = {exp_ce, 1'(m_mode == M_LOAD), m_plv,
                   1'(m_mode == M_LOAD || m_mode == M_RUN || m_mode == M_STEP),
                   1'(m_mode == M_HALT), 2'(m_cause), 16'(m_ret)};
        act_vec = {core_ce, pc_load, pc_load_val, running, halted, halt_cause, retired};
    endtask

    task automatic go_halt(input int cause);
        m_mode = M_HALT; m_cause = cause; m_stall = 0;
    endtask

    // Rising edge: the sequencing rules applied to the inputs held this cycle.
    task automatic advance();
        bit bp;
        @(posedge clk);
        bp = bp_now();
        if (exp_ce && m_ret != 65535) m_ret++;
        case (m_mode)
            M_IDLE, M_HALT: begin
                if (!ctl_stop) begin
                    if (ctl_start) begin
                        m_mode = M_LOAD; m_plv = ctl_entry; m_ret = 0; m_cause = 0;
                    end else if (m_mode == M_HALT && ctl_cont) begin
                        m_mode = M_RUN; m_resume = 1;
                    end else if (m_mode == M_HALT && ctl_step) begin
                        m_mode = M_STEP;
                    end
                end
            end
            M_LOAD: begin
                m_mode = M_RUN; m_resume = 1; m_pc = m_plv;
            end
            M_RUN: begin
                if (m_stall > 0) begin
                    if (ctl_stop) go_halt(1);
                    else m_stall--;
                end else begin
                    m_resume = 0;
                    if (ctl_stop)      go_halt(1);
                    else if (bp)       go_halt(2);
                    else if (op_halt)  go_halt(3);
                    else if (op_wait)  m_stall = int'(op_wait_cnt);
                end
            end
            M_STEP: go_halt(ctl_stop ? 1 : 3);
            default: m_mode = M_IDLE;
        endcase
        if (exp_ce) m_pc = m_pc + 8'd1;
    endtask

    task automatic assert_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ctl_start = 0; ctl_stop = 0; ctl_cont = 0; ctl_step = 0;
        #1;
        model_reset();
    endtask

    task automatic clear_prog();
        for (int a = 0; a < 256; a++) begin
            prog_halt[a] = 0; prog_wait[a] = 0; prog_cnt[a] = 8'h00;
        end
    endtask

    task automatic test_reset();
        clear_prog();
        assert_reset();
        act_vec = {core_ce, pc_load, pc_load_val, running, halted, halt_cause, retired};
        n_checks++;
        if (act_vec !== 30'h0) $display("FAIL reset_values: got %h want %h", act_vec, 30'h0);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if ({core_ce, running, halted} !== 3'b000)
            $display("FAIL reset_hold: got %b want 000", {core_ce, running, halted});
        else n_pass++;
    endtask

    // Start at 0x10, WAIT of 3 at 0x12, breakpoint at 0x14, HALT op at 0x20.
    task automatic test_run_wait_bp_halt();
        clear_prog();
        prog_wait[8'h12] = 1; prog_cnt[8'h12] = 8'd3;
        prog_halt[8'h20] = 1;
        ctl_bp_en = 1; ctl_bp_addr = 8'h14;
        for (int i = 0; i < 28; i++) begin
            drive(i == 0, 0, i == 10, i == 24, 8'h10);
            n_checks++;
            if (act_vec !== exp_vec) $display("FAIL run_cycle %0d: got %h want %h", i, act_vec, exp_vec);
            else n_pass++;
            if (i == 1) begin
                n_checks++;
                if ({pc_load, pc_load_val} !== 9'h110)
                    $display("FAIL start_load: got %h want 110", {pc_load, pc_load_val});
                else n_pass++;
            end
            if (i == 4 || i == 8 || i == 11) begin
                n_checks++;
                if (core_ce !== 1'b1) $display("FAIL commit_%0d: got %b want 1", i, core_ce);
                else n_pass++;
            end
            if (i >= 5 && i <= 7) begin
                n_checks++;
                if ({core_ce, running} !== 2'b01) $display("FAIL wait_stall_%0d: got %b want 01", i, {core_ce, running});
                else n_pass++;
            end
            if (i == 10) begin
                n_checks++;
                if ({halted, halt_cause, pc, retired} !== {1'b1, 2'd2, 8'h14, 16'd4})
                    $display("FAIL bp_halt: got %h want %h", {halted, halt_cause, pc, retired}, {1'b1, 2'd2, 8'h14, 16'd4});
                else n_pass++;
            end
            if (i == 23 || i == 25) begin
                n_checks++;
                if ({pc, core_ce} !== {8'h20, 1'b0}) $display("FAIL halt_op_%0d: got %h want 40", i, {pc, core_ce});
                else n_pass++;
            end
            if (i == 26) begin
                n_checks++;
                if ({halted, halt_cause} !== 3'b111) $display("FAIL step_on_halt: got %b want 111", {halted, halt_cause});
                else n_pass++;
            end
            advance();
        end
        ctl_bp_en = 0;
    endtask

    // Stop, single-step, stop during WAIT, start+stop collision, reset in RUN.
    task automatic test_step_stop_reset();
        clear_prog();
        prog_wait[8'h31] = 1; prog_cnt[8'h31] = 8'd10;
        for (int i = 0; i < 20; i++) begin
            drive(i == 0 || i == 14 || i == 16, i == 2 || i == 12 || i == 14, i == 5, i == 3,
                  (i < 14) ? 8'h30 : 8'h40);
            n_checks++;
            if (act_vec !== exp_vec) $display("FAIL step_cycle %0d: got %h want %h", i, act_vec, exp_vec);
            else n_pass++;
            if (i == 4) begin
                n_checks++;
                if ({core_ce, pc} !== {1'b1, 8'h30}) $display("FAIL step_commit: got %h want 130", {core_ce, pc});
                else n_pass++;
            end
            if (i == 5) begin
                n_checks++;
                if ({halted, halt_cause, retired} !== {1'b1, 2'd3, 16'd1})
                    $display("FAIL step_done: got %h want %h", {halted, halt_cause, retired}, {1'b1, 2'd3, 16'd1});
                else n_pass++;
            end
            if (i == 13 || i == 15) begin
                n_checks++;
                if ({halted, halt_cause, pc_load} !== 4'b1010)
                    $display("FAIL stop_halt_%0d: got %b want 1010", i, {halted, halt_cause, pc_load});
                else n_pass++;
            end
            advance();
        end
        assert_reset();
        act_vec = {core_ce, pc_load, pc_load_val, running, halted, halt_cause, retired};
        n_checks++;
        if (act_vec !== 30'h0) $display("FAIL reset_in_run: got %h want %h", act_vec, 30'h0);
        else n_pass++;
        @(posedge clk);
    endtask

    task automatic test_random();
        for (int a = 0; a < 256; a++) begin
            prog_halt[a] = ($urandom_range(0, 15) == 0);
            prog_wait[a] = ($urandom_range(0, 7) == 0);
            prog_cnt[a]  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 4));
        end
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) begin
                ctl_bp_en   = 1'($urandom_range(0, 1));
                ctl_bp_addr = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 499) == 0) begin
                assert_reset();
                act_vec = {core_ce, pc_load, pc_load_val, running, halted, halt_cause, retired};
                n_checks++;
                if (act_vec !== 30'h0) $display("FAIL rand_reset %0d: got %h want 0", i, act_vec);
                else n_pass++;
                @(posedge clk);
            end else begin
                drive($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
                      $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                      8'($urandom_range(0, 255)));
                n_checks++;
                if (act_vec !== exp_vec) $display("FAIL rand_cycle %0d: got %h want %h", i, act_vec, exp_vec);
                else n_pass++;
                advance();
            end
        end
    endtask

    initial begin
        model_reset();
        clear_prog();
        test_reset();
        test_run_wait_bp_halt();
        test_step_stop_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
